// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: a 4-byte little-endian word count header followed by N
// little-endian words, written to imemory from BASE_ADDR upward while the core is held in reset.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_hold,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] word_count;
  logic [23:0] shift_reg;
  logic        xfer;
  logic [31:0] full_word;
  logic [31:0] next_written;
  logic [31:0] write_addr;

  // Bytes enter at the top and shift down, so after four transfers the first byte sits in bits 7:0.
  assign xfer         = in_valid && in_ready;
  assign full_word    = {in_data, shift_reg};
  assign next_written = {16'd0, words_written} + 32'd1;
  assign write_addr   = BASE_ADDR + {14'd0, words_written, 2'b00};

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      in_ready       <= 1'b0;
      mem_read_write <= 1'b0;
      mem_address    <= BASE_ADDR;
      mem_data_in    <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      core_hold      <= 1'b1;
      words_written  <= 16'd0;
      byte_cnt       <= 2'd0;
      word_count     <= 32'd0;
      shift_reg      <= 24'd0;
    end else begin
      mem_read_write <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state         <= S_HEADER;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            core_hold     <= 1'b1;
            words_written <= 16'd0;
            byte_cnt      <= 2'd0;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= full_word[31:8];
            if (byte_cnt == 2'd3) begin
              word_count <= full_word;
              if (full_word == 32'd0) begin
                state     <= S_DONE;
                in_ready  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                core_hold <= 1'b0;
              end else if (full_word > MAX_W) begin
                state    <= S_ERROR;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                error    <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= full_word[31:8];
            if (byte_cnt == 2'd3) begin
              state          <= S_WRITE;
              in_ready       <= 1'b0;
              mem_read_write <= 1'b1;
              mem_address    <= write_addr;
              mem_data_in    <= full_word;
            end
          end
        end
        S_WRITE: begin
          words_written <= next_written[15:0];
          if (next_written == word_count) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state    <= S_DATA;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the fetch path. Fetch only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into imemory through its address/data_in/read_write port, starting at the reset PC.
- Holds the core in reset (core_hold) until the program image is fully loaded.

Parameters:
- BASE_ADDR, 32'h01000000, byte address of the first word written; matches the fetch reset PC.
- MAX_WORDS, 1024, largest accepted image size in words; larger images are rejected.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that begins a load session
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data
- in_ready  output  1  block can accept a byte this cycle
- mem_address  output  32  imemory byte address
- mem_data_in  output  32  imemory write data
- mem_read_write  output  1  1 = write strobe to imemory, 0 = no write (read)
- busy  output  1  load session in progress
- done  output  1  image fully written; sticky
- error  output  1  header word count exceeded MAX_WORDS; sticky
- core_hold  output  1  drives the core's reset; deasserted only in DONE
- words_written  output  16  count of words committed this session

Behaviour:
- States: IDLE, HEADER, DATA, WRITE, DONE, ERROR.
- Reset values, applied on the next clock edge while reset is high, regardless of state or a partial word in flight:
  - state = IDLE; in_ready = 0; mem_read_write = 0.
  - mem_address = BASE_ADDR; mem_data_in = 0.
  - busy = done = error = 0; core_hold = 1; words_written = 0.
  - byte counter = 0; word count = 0.
- Byte transfer occurs when in_valid && in_ready are high at a rising edge. in_data is sampled only on transfer.
- in_ready = 1 only in HEADER and DATA. It is 0 in WRITE, IDLE, DONE and ERROR.
- busy = 1 in HEADER, DATA and WRITE.
- IDLE -> HEADER on start.
  - start also clears done, error, words_written and the byte counter.
- start is ignored in HEADER, DATA and WRITE. It is accepted in IDLE, DONE and ERROR.
- HEADER: receives 4 bytes forming word count N, little-endian (first byte = bits 7:0).
  - After the 4th byte: N == 0 -> DONE, with no writes issued.
  - N > MAX_WORDS -> ERROR.
  - Otherwise -> DATA.
- DATA: receives 4 bytes and assembles them little-endian into a word register.
  - After the 4th byte -> WRITE on the next cycle.
- WRITE lasts exactly 1 cycle:
  - mem_read_write = 1.
  - mem_address = BASE_ADDR + 4*words_written, using 32-bit arithmetic.
  - mem_data_in = assembled word.
  - At the end of the cycle, words_written increments. If the new value equals N -> DONE, else -> DATA.
- mem_address and mem_data_in are registered. mem_read_write is high only during WRITE.
- Per-word latency: the write strobe appears exactly 1 cycle after the 4th data byte transfer. Minimum 5 cycles per word.
- DONE: done = 1 and core_hold = 0. Stays in DONE until start or reset.
- ERROR: error = 1, core_hold = 1, no writes. Stays in ERROR until start or reset.
- Gaps in in_valid stall the FSM indefinitely. No timeout.
- Bytes presented outside HEADER/DATA are not consumed, because in_ready = 0.
- Reset mid-load abandons the session. Words already written remain in memory. core_hold stays 1.
- N == MAX_WORDS is legal. The final address is BASE_ADDR + 4*(MAX_WORDS-1).

Test Plan:
- Reset, then start, then header 02 00 00 00, then bytes 13 00 00 00 / 93 00 10 00 -> two write strobes:
  - addr 0x01000000 data 0x00000013.
  - addr 0x01000004 data 0x00100093.
  - Then done = 1, core_hold = 0, words_written = 2.
- Header 00 00 00 00 -> DONE 1 cycle after the 4th header byte, with zero mem_read_write pulses.
- Header 01 04 00 00 (N = 1025, MAX_WORDS = 1024) -> error = 1, core_hold = 1, in_ready = 0. A subsequent start clears error and returns in_ready = 1 in HEADER.
- in_valid toggled randomly during a 3-word load -> identical writes and addresses as the back-to-back case. in_ready is 0 for exactly one cycle per word (WRITE).
- Reset asserted after 2 data bytes of word 0 -> all outputs at reset values on the next edge, and no write strobe. A new start with a 1-word image writes 0x01000000.
- start pulsed during DATA -> ignored, and the session completes normally. N = 1024 image -> last write at address 0x01000FFC, then done.
